// File: rtl/hour_set_ctrl.sv
// Seconds counter and RUN/SET_HOUR/SET_MIN sequencer that issues minute/hour advance strobes.
// Optional auto-repeat of held btn_inc in SET modes: define HOUR_SET_CTRL_AUTOREPEAT_EN.
module hour_set_ctrl #(
    parameter int unsigned REPEAT_DELAY = 8_000_000,
    parameter int unsigned REPEAT_RATE  = 2_000_000,
    parameter int unsigned CNT_W        = 24
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       tick,
    input  logic       min_wrap,
    input  logic       btn_mode,
    input  logic       btn_inc,
    output logic       min_adv,
    output logic       hour_adv,
    output logic [1:0] mode,
    output logic [2:0] sec10,
    output logic [3:0] sec,
    output logic       blink
);

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        SET_HOUR = 2'b01,
        SET_MIN  = 2'b10,
        BAD      = 2'b11
    } mode_t;

    mode_t      state, state_n;
    logic [1:0] mode_sync, inc_sync;
    logic       mode_prev, inc_prev;
    logic       mode_rise_c, inc_rise_c, rpt_fire_c, adv_c;
    logic [2:0] sec10_n;
    logic [3:0] sec_n;
    logic       blink_n, min_adv_n, hour_adv_n;

    // Two-flop synchronizers followed by rising-edge detectors
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mode_sync <= 2'b00;
            inc_sync  <= 2'b00;
            mode_prev <= 1'b0;
            inc_prev  <= 1'b0;
        end else begin
            mode_sync <= {mode_sync[0], btn_mode};
            inc_sync  <= {inc_sync[0], btn_inc};
            mode_prev <= mode_sync[1];
            inc_prev  <= inc_sync[1];
        end
    end

    assign mode_rise_c = mode_sync[1] & ~mode_prev;
    assign inc_rise_c  = inc_sync[1] & ~inc_prev;

`ifdef HOUR_SET_CTRL_AUTOREPEAT_EN
    logic [CNT_W-1:0] rpt_cnt, rpt_cnt_n;
    logic             rpt_on, rpt_on_n;

    // Down-counter armed by the press edge; fires after DELAY, then every RATE cycles
    always_comb begin
        rpt_on_n   = rpt_on;
        rpt_cnt_n  = rpt_cnt;
        rpt_fire_c = 1'b0;
        if (mode_rise_c || state == RUN || state == BAD || !inc_sync[1]) begin
            rpt_on_n  = 1'b0;
            rpt_cnt_n = '0;
        end else if (inc_rise_c) begin
            rpt_on_n  = 1'b1;
            rpt_cnt_n = CNT_W'(REPEAT_DELAY - 1);
        end else if (rpt_on) begin
            if (rpt_cnt == '0) begin
                rpt_fire_c = 1'b1;
                rpt_cnt_n  = CNT_W'(REPEAT_RATE - 1);
            end else begin
                rpt_cnt_n = rpt_cnt - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rpt_on  <= 1'b0;
            rpt_cnt <= '0;
        end else begin
            rpt_on  <= rpt_on_n;
            rpt_cnt <= rpt_cnt_n;
        end
    end
`else
    logic unused_cfg;
    assign rpt_fire_c = 1'b0;
    assign unused_cfg = ^{CNT_W'(REPEAT_DELAY), CNT_W'(REPEAT_RATE)};
`endif

    assign adv_c = inc_rise_c | rpt_fire_c;

    // Next mode, seconds, blink and strobes; a mode edge pre-empts tick and inc in that cycle
    always_comb begin
        state_n    = state;
        sec10_n    = sec10;
        sec_n      = sec;
        blink_n    = blink;
        min_adv_n  = 1'b0;
        hour_adv_n = 1'b0;
        case (state)
            RUN: begin
                blink_n = 1'b0;
                if (mode_rise_c) begin
                    state_n = SET_HOUR;
                    sec10_n = 3'd0;
                    sec_n   = 4'd0;
                end else if (tick) begin
                    if (sec == 4'd9) begin
                        sec_n = 4'd0;
                        if (sec10 == 3'd5) begin
                            sec10_n    = 3'd0;
                            min_adv_n  = 1'b1;
                            hour_adv_n = min_wrap;
                        end else begin
                            sec10_n = sec10 + 3'd1;
                        end
                    end else begin
                        sec_n = sec + 4'd1;
                    end
                end
            end
            SET_HOUR: begin
                sec10_n = 3'd0;
                sec_n   = 4'd0;
                if (mode_rise_c) begin
                    state_n = SET_MIN;
                end else begin
                    if (tick) blink_n = ~blink;
                    if (adv_c) hour_adv_n = 1'b1;
                end
            end
            SET_MIN: begin
                sec10_n = 3'd0;
                sec_n   = 4'd0;
                if (mode_rise_c) begin
                    state_n = RUN;
                    blink_n = 1'b0;
                end else begin
                    if (tick) blink_n = ~blink;
                    if (adv_c) min_adv_n = 1'b1;
                end
            end
            default: begin
                state_n = RUN;
                blink_n = 1'b0;
                sec10_n = 3'd0;
                sec_n   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= RUN;
            sec10    <= 3'd0;
            sec      <= 4'd0;
            blink    <= 1'b0;
            min_adv  <= 1'b0;
            hour_adv <= 1'b0;
        end else begin
            state    <= state_n;
            sec10    <= sec10_n;
            sec      <= sec_n;
            blink    <= blink_n;
            min_adv  <= min_adv_n;
            hour_adv <= hour_adv_n;
        end
    end

    assign mode = state;

endmodule

// File: tb/tb_hour_set_ctrl.sv
// Self-checking bench for hour_set_ctrl: behavioural model plus directed literal checks and random stimulus.
module tb_hour_set_ctrl;
    localparam int unsigned RD = 10;
    localparam int unsigned RR = 4;

    logic       clock = 1'b0;
    logic       reset, tick, min_wrap, btn_mode, btn_inc;
    logic       min_adv, hour_adv, blink;
    logic [1:0] mode;
    logic [2:0] sec10;
    logic [3:0] sec;

    int checks   = 0;
    int failures = 0;

    hour_set_ctrl #(.REPEAT_DELAY(RD), .REPEAT_RATE(RR), .CNT_W(24)) dut (
        .clock(clock), .reset(reset), .tick(tick), .min_wrap(min_wrap),
        .btn_mode(btn_mode), .btn_inc(btn_inc), .min_adv(min_adv),
        .hour_adv(hour_adv), .mode(mode), .sec10(sec10), .sec(sec), .blink(blink)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: seconds as 0..59, mode as 0/1/2, button samples kept as a short history
    int       m_secs = 0, m_mode = 0, r_rel = 0;
    bit       m_blink = 0, m_min = 0, m_hour = 0, r_on = 0;
    bit [2:0] hm = '0, hi = '0;
    bit       me, ie, lvl, fire;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_secs = 0; m_mode = 0; m_blink = 0; m_min = 0; m_hour = 0;
            r_on = 0; r_rel = 0; hm = '0; hi = '0;
        end else begin
            me   = hm[1] & ~hm[2];
            ie   = hi[1] & ~hi[2];
            lvl  = hi[1];
            fire = 0;
            m_min  = 0;
            m_hour = 0;
            if (me || m_mode == 0 || !lvl) begin
                r_on = 0;
            end else if (ie) begin
                r_on = 1; r_rel = 0; fire = 1;
            end else if (r_on) begin
                r_rel++;
`ifdef HOUR_SET_CTRL_AUTOREPEAT_EN
                if (r_rel == int'(RD) || (r_rel > int'(RD) && (r_rel - int'(RD)) % int'(RR) == 0))
                    fire = 1;
`endif
            end
            case (m_mode)
                0: begin
                    if (me) begin
                        m_mode = 1; m_secs = 0;
                    end else if (tick) begin
                        if (m_secs == 59) begin
                            m_secs = 0; m_min = 1; m_hour = min_wrap;
                        end else begin
                            m_secs++;
                        end
                    end
                end
                1: begin
                    if (me) m_mode = 2;
                    else begin
                        if (tick) m_blink = !m_blink;
                        if (fire) m_hour = 1;
                    end
                end
                default: begin
                    if (me) begin
                        m_mode = 0; m_blink = 0;
                    end else begin
                        if (tick) m_blink = !m_blink;
                        if (fire) m_min = 1;
                    end
                end
            endcase
            hm = {hm[1:0], btn_mode};
            hi = {hi[1:0], btn_inc};
        end
    end

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clock) begin
        if (reset === 1'b0) begin
            check("cyc_min_adv",  int'(min_adv),  int'(m_min));
            check("cyc_hour_adv", int'(hour_adv), int'(m_hour));
            check("cyc_mode",     int'(mode),     m_mode);
            check("cyc_sec10",    int'(sec10),    m_secs / 10);
            check("cyc_sec",      int'(sec),      m_secs % 10);
            check("cyc_blink",    int'(blink),    int'(m_blink));
        end
    end

    task automatic do_tick(input bit w);
        tick = 1'b1; min_wrap = w;
        @(negedge clock);
        tick = 1'b0; min_wrap = 1'b0;
    endtask

    task automatic press_mode(input int exp_mode);
        btn_mode = 1'b1;
        repeat (3) @(negedge clock);
        check("mode_after_press", int'(mode), exp_mode);
        repeat (2) @(negedge clock);
        btn_mode = 1'b0;
        repeat (4) @(negedge clock);
    endtask

    task automatic press_inc(output int hcnt, output int mcnt);
        hcnt = 0; mcnt = 0;
        btn_inc = 1'b1;
        for (int c = 0; c < 14; c++) begin
            if (c == 8) btn_inc = 1'b0;
            @(negedge clock);
            if (hour_adv) hcnt++;
            if (min_adv) mcnt++;
        end
    endtask

    int       hc, mc, exp_n, got_n, waited;
    int       rel_q[$];
    int       exp_rel[6];
    bit [3:0] blink_pat;

    initial begin
        exp_rel = '{0, 10, 14, 18, 22, 26};
        blink_pat = 4'b0101;
        tick = 0; min_wrap = 0; btn_mode = 0; btn_inc = 0;
        reset = 1'b1;
        repeat (3) @(negedge clock);
        check("rst_mode", int'(mode), 0);
        check("rst_sec", int'({sec10, sec}), 0);
        check("rst_strobes", int'({min_adv, hour_adv, blink}), 0);
        reset = 1'b0;
        @(negedge clock);

        // 59 ticks then the minute carry
        repeat (59) begin do_tick(0); @(negedge clock); end
        check("sec59_tens", int'(sec10), 5);
        check("sec59_units", int'(sec), 9);
        do_tick(0);
        check("wrap_min_adv", int'(min_adv), 1);
        check("wrap_hour_adv", int'(hour_adv), 0);
        check("wrap_sec", int'({sec10, sec}), 0);
        @(negedge clock);
        check("wrap_min_adv_drop", int'(min_adv), 0);

        // Minute carry with min_wrap produces both strobes together
        repeat (59) begin do_tick(0); @(negedge clock); end
        do_tick(1);
        check("carry_min_adv", int'(min_adv), 1);
        check("carry_hour_adv", int'(hour_adv), 1);
        check("carry_sec", int'({sec10, sec}), 0);
        @(negedge clock);
        check("carry_drop", int'({min_adv, hour_adv}), 0);

        // Enter SET_HOUR at 37 seconds
        repeat (37) begin do_tick(0); @(negedge clock); end
        check("sec37", int'({1'b0, sec10, sec}), 8'h37);
        press_mode(1);
        check("set_hour_sec", int'({sec10, sec}), 0);
        for (int i = 0; i < 4; i++) begin
            do_tick(0);
            check("blink_pattern", int'(blink), int'(blink_pat[i]));
            @(negedge clock);
        end
        press_inc(hc, mc);
        check("set_hour_inc_hour", hc, 1);
        check("set_hour_inc_min", mc, 0);

        // SET_MIN: no hour carry even with min_wrap
        press_mode(2);
        min_wrap = 1'b1;
        press_inc(hc, mc);
        min_wrap = 1'b0;
        check("set_min_inc_min", mc, 1);
        check("set_min_inc_hour", hc, 0);
        press_mode(0);
        check("run_blink", int'(blink), 0);

        // Held btn_inc in SET_HOUR
        press_mode(1);
        rel_q.delete();
        btn_inc = 1'b1;
        for (int c = 0; c < 45; c++) begin
            if (c == 30) btn_inc = 1'b0;
            @(negedge clock);
            if (hour_adv) rel_q.push_back(c);
        end
`ifdef HOUR_SET_CTRL_AUTOREPEAT_EN
        exp_n = 6;
`else
        exp_n = 1;
`endif
        got_n = rel_q.size();
        check("hold_strobe_count", got_n, exp_n);
        for (int i = 1; i < exp_n && i < got_n; i++)
            check("hold_strobe_spacing", rel_q[i] - rel_q[0], exp_rel[i]);

        // Async reset while hour_adv is high
        btn_inc = 1'b1;
        waited = 0;
        while (hour_adv !== 1'b1 && waited < 10) begin
            @(negedge clock);
            waited++;
        end
        check("strobe_wait_timeout", int'(hour_adv === 1'b1), 1);
        #1 reset = 1'b1;
        #1;
        check("async_hour_adv", int'(hour_adv), 0);
        check("async_mode", int'(mode), 0);
        check("async_sec", int'({sec10, sec}), 0);
        check("async_min_blink", int'({min_adv, blink}), 0);
        btn_inc = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        repeat (4) @(negedge clock);
        check("post_reset_mode", int'(mode), 0);

        // Randomized traffic checked cycle by cycle
        for (int c = 0; c < 3000; c++) begin
            tick     = ($urandom_range(0, 3) == 0);
            min_wrap = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 11) == 0) btn_mode = ~btn_mode;
            if ($urandom_range(0, 9) == 0) btn_inc = ~btn_inc;
            @(negedge clock);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
